// File: rtl/game_ctrl_np.sv
// ============================================================================
// Module  : game_ctrl_np
// Purpose : N-player quiz game sequencer with answer arbitration, internal HP,
//           answer time limit, wrong-answer lockout and game-over detection.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module game_ctrl_np #(
    parameter int NPLAYER    = 2,
    parameter int HP_W       = 3,
    parameter int HP_INIT    = 3,
    parameter int DAMAGE     = 1,
    parameter int ANS_TICKS  = 10,
    parameter int HOLD_TICKS = 1
) (
    input  logic                                                 CLK,
    input  logic                                                 RST,
    input  logic                                                 TICK,
    input  logic [NPLAYER-1:0]                                   START,
    input  logic                                                 Q_READY,
    input  logic                                                 Q_SHOW,
    input  logic [NPLAYER-1:0]                                   ANS_VALID,
    input  logic [NPLAYER-1:0]                                   ANS_OK,
    output logic [3:0]                                           STATE,
    output logic [((NPLAYER > 1) ? $clog2(NPLAYER) : 1)-1:0]     WHO,
    output logic [NPLAYER*HP_W-1:0]                              HP,
    output logic [NPLAYER-1:0]                                   LOCK,
    output logic [NPLAYER-1:0]                                   ANS_EN,
    output logic [$clog2(ANS_TICKS+1)-1:0]                       TIME_LEFT
);

    localparam int WHO_W  = (NPLAYER > 1) ? $clog2(NPLAYER) : 1;
    localparam int TL_W   = $clog2(ANS_TICKS + 1);
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [3:0] c_st_ready    = 4'h2;
    localparam logic [3:0] c_st_question = 4'h3;
    localparam logic [3:0] c_st_input    = 4'h4;
    localparam logic [3:0] c_st_timeout  = 4'h5;
    localparam logic [3:0] c_st_draw     = 4'h6;
    localparam logic [3:0] c_st_wrong    = 4'h7;
    localparam logic [3:0] c_st_hit      = 4'h8;
    localparam logic [3:0] c_st_over     = 4'hA;

    logic [3:0]              state_q, state_d;
    logic [WHO_W-1:0]        who_q, who_d;
    logic [NPLAYER*HP_W-1:0] hp_q, hp_d;
    logic [NPLAYER-1:0]      lock_q, lock_d;
    logic [NPLAYER-1:0]      ans_en_q, ans_en_d;
    logic [TL_W-1:0]         time_q, time_d;
    logic [NPLAYER-1:0]      rdy_q, rdy_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;

    logic [NPLAYER-1:0]      w_valid, w_ok, w_bad, w_new_lock;
    logic [WHO_W-1:0]        w_ok_idx, w_bad_idx, w_alive_idx;
    logic [HP_W-1:0]         w_hp_j;
    int                      w_ok_cnt, w_alive_cnt;

    always_comb begin
        w_valid     = ANS_VALID & ~lock_q;
        w_ok        = w_valid & ANS_OK;
        w_bad       = w_valid & ~ANS_OK;
        w_new_lock  = lock_q | w_bad;
        w_ok_cnt    = 0;
        w_alive_cnt = 0;
        w_ok_idx    = '0;
        w_bad_idx   = '0;
        w_alive_idx = '0;
        w_hp_j      = '0;
        // Descending scan so the lowest set index is the one left behind.
        for (int i = NPLAYER - 1; i >= 0; i--) begin
            if (w_ok[i]) begin
                w_ok_cnt = w_ok_cnt + 1;
                w_ok_idx = WHO_W'(i);
            end
            if (w_bad[i]) begin
                w_bad_idx = WHO_W'(i);
            end
            if (hp_q[i*HP_W +: HP_W] != '0) begin
                w_alive_cnt = w_alive_cnt + 1;
                w_alive_idx = WHO_W'(i);
            end
        end

        state_d = state_q;
        who_d   = who_q;
        hp_d    = hp_q;
        lock_d  = lock_q;
        time_d  = time_q;
        rdy_d   = rdy_q;
        hold_d  = '0;

        case (state_q)
            c_st_ready: begin
                rdy_d = rdy_q | START;
                if ((&rdy_q) && Q_READY) begin
                    state_d = c_st_question;
                    rdy_d   = '0;
                end
            end
            c_st_question: begin
                if (Q_SHOW && Q_READY) begin
                    state_d = c_st_input;
                    time_d  = TL_W'(ANS_TICKS);
                    lock_d  = '0;
                end
            end
            c_st_input: begin
                if (!Q_SHOW) begin
                    state_d = c_st_question;
                end else if (w_ok_cnt == 1) begin
                    state_d = c_st_hit;
                    who_d   = w_ok_idx;
                    // Damage lands on the transition edge, once per hit.
                    for (int j = 0; j < NPLAYER; j++) begin
                        w_hp_j = hp_q[j*HP_W +: HP_W];
                        if (WHO_W'(j) != w_ok_idx && w_hp_j != '0) begin
                            hp_d[j*HP_W +: HP_W] = (int'(w_hp_j) > DAMAGE) ?
                                                   w_hp_j - HP_W'(DAMAGE) : '0;
                        end
                    end
                end else if (w_ok_cnt > 1) begin
                    state_d = c_st_draw;
                end else if (w_bad != '0) begin
                    lock_d  = w_new_lock;
                    who_d   = w_bad_idx;
                    state_d = (&w_new_lock) ? c_st_timeout : c_st_wrong;
                end else if (TICK) begin
                    if (time_q == TL_W'(1)) begin
                        time_d  = '0;
                        state_d = c_st_timeout;
                    end else if (time_q != '0) begin
                        time_d = time_q - TL_W'(1);
                    end
                end
            end
            c_st_wrong, c_st_hit, c_st_draw, c_st_timeout: begin
                hold_d = hold_q;
                if (TICK) begin
                    if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                        hold_d = '0;
                        if (state_q == c_st_wrong) begin
                            state_d = c_st_input;
                        end else if (state_q == c_st_hit && w_alive_cnt <= 1) begin
                            // No survivors keeps the scorer as the winner.
                            state_d = c_st_over;
                            if (w_alive_cnt == 1) begin
                                who_d = w_alive_idx;
                            end
                        end else begin
                            state_d = c_st_ready;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            c_st_over: begin
                rdy_d = rdy_q | START;
                if (&rdy_q) begin
                    hp_d    = {NPLAYER{HP_W'(HP_INIT)}};
                    rdy_d   = '0;
                    state_d = c_st_ready;
                end
            end
            default: begin
                state_d = c_st_ready;
            end
        endcase

        ans_en_d = (state_d == c_st_input) ? ~lock_d : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= c_st_ready;
            who_q    <= '0;
            hp_q     <= {NPLAYER{HP_W'(HP_INIT)}};
            lock_q   <= '0;
            ans_en_q <= '0;
            time_q   <= TL_W'(ANS_TICKS);
            rdy_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            who_q    <= who_d;
            hp_q     <= hp_d;
            lock_q   <= lock_d;
            ans_en_q <= ans_en_d;
            time_q   <= time_d;
            rdy_q    <= rdy_d;
            hold_q   <= hold_d;
        end
    end

    assign STATE     = state_q;
    assign WHO       = who_q;
    assign HP        = hp_q;
    assign LOCK      = lock_q;
    assign ANS_EN    = ans_en_q;
    assign TIME_LEFT = time_q;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl_np.sv
// ============================================================================
// Module  : tb_game_ctrl_np
// Purpose : Directed self-checking bench for game_ctrl_np (2- and 3-player).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_game_ctrl_np;

    logic       CLK = 1'b0;
    logic       RST;
    logic       TICK;
    logic       Q_READY;
    logic       Q_SHOW;

    logic [1:0] start2, av2, ok2;
    logic [3:0] state2;
    logic [0:0] who2;
    logic [5:0] hp2;
    logic [1:0] lock2, en2;
    logic [3:0] tl2;

    logic [2:0] start3, av3, ok3;
    logic [3:0] state3;
    logic [1:0] who3;
    logic [8:0] hp3;
    logic [2:0] lock3, en3;
    logic [3:0] tl3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    game_ctrl_np #(.NPLAYER(2)) u2 (
        .CLK(CLK), .RST(RST), .TICK(TICK), .START(start2), .Q_READY(Q_READY),
        .Q_SHOW(Q_SHOW), .ANS_VALID(av2), .ANS_OK(ok2), .STATE(state2),
        .WHO(who2), .HP(hp2), .LOCK(lock2), .ANS_EN(en2), .TIME_LEFT(tl2)
    );

    game_ctrl_np #(.NPLAYER(3), .HP_INIT(1)) u3 (
        .CLK(CLK), .RST(RST), .TICK(TICK), .START(start3), .Q_READY(Q_READY),
        .Q_SHOW(Q_SHOW), .ANS_VALID(av3), .ANS_OK(ok3), .STATE(state3),
        .WHO(who3), .HP(hp3), .LOCK(lock3), .ANS_EN(en3), .TIME_LEFT(tl3)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Both players ready, question shown: READY -> QUESTION -> INPUT.
    task automatic to_input2();
        start2 = 2'b11;
        cyc();
        start2 = 2'b00;
        cyc();
        cyc();
    endtask

    initial begin
        RST = 1'b1; TICK = 1'b0; Q_READY = 1'b0; Q_SHOW = 1'b0;
        start2 = '0; av2 = '0; ok2 = '0;
        start3 = '0; av3 = '0; ok3 = '0;
        cyc();
        cyc();
        chk("rst_state", 32'(state2), 32'h2);
        chk("rst_who", 32'(who2), 32'h0);
        chk("rst_lock", 32'(lock2), 32'h0);
        chk("rst_ans_en", 32'(en2), 32'h0);
        chk("rst_time", 32'(tl2), 32'd10);
        chk("rst_hp", 32'(hp2), 32'b011_011);
        chk("rst_hp3", 32'(hp3), 32'b001_001_001);
        RST = 1'b0;

        // Staggered START pulses; answering opened separately.
        Q_READY = 1'b1;
        start2 = 2'b01; cyc(); start2 = 2'b00;
        cyc();
        chk("ready_half", 32'(state2), 32'h2);
        start2 = 2'b10; cyc(); start2 = 2'b00;
        cyc();
        chk("question", 32'(state2), 32'h3);
        Q_SHOW = 1'b1;
        cyc();
        chk("input", 32'(state2), 32'h4);
        chk("input_time", 32'(tl2), 32'd10);
        chk("input_en", 32'(en2), 32'b11);

        // Player 0 scores.
        av2 = 2'b01; ok2 = 2'b01; cyc(); av2 = '0; ok2 = '0;
        chk("hit_state", 32'(state2), 32'h8);
        chk("hit_who", 32'(who2), 32'h0);
        cyc();
        chk("hit_hold", 32'(state2), 32'h8);
        chk("hit_hp", 32'(hp2), 32'b010_011);
        TICK = 1'b1; cyc(); TICK = 1'b0;
        chk("hit_exit", 32'(state2), 32'h2);

        // Tick down once, then player 1 answers wrong.
        to_input2();
        chk("input2", 32'(state2), 32'h4);
        TICK = 1'b1; cyc(); TICK = 1'b0;
        chk("tick_dec", 32'(tl2), 32'd9);
        av2 = 2'b10; ok2 = 2'b00; cyc(); av2 = '0;
        chk("wrong_state", 32'(state2), 32'h7);
        chk("wrong_lock", 32'(lock2), 32'b10);
        chk("wrong_who", 32'(who2), 32'h1);
        TICK = 1'b1; cyc(); TICK = 1'b0;
        chk("wrong_back", 32'(state2), 32'h4);
        chk("wrong_time", 32'(tl2), 32'd9);
        chk("wrong_en", 32'(en2), 32'b01);
        av2 = 2'b10; ok2 = 2'b10; cyc(); av2 = '0; ok2 = '0;
        chk("locked_ignored", 32'(state2), 32'h4);
        // Last unlocked player wrong: everyone locked -> TIMEOUT.
        av2 = 2'b01; ok2 = 2'b00; cyc(); av2 = '0;
        chk("alllock_state", 32'(state2), 32'h5);
        chk("alllock_lock", 32'(lock2), 32'b11);
        chk("alllock_time", 32'(tl2), 32'd9);
        TICK = 1'b1; cyc(); TICK = 1'b0;
        chk("alllock_exit", 32'(state2), 32'h2);

        // Simultaneous correct answers.
        to_input2();
        av2 = 2'b11; ok2 = 2'b11; cyc(); av2 = '0; ok2 = '0;
        chk("draw_state", 32'(state2), 32'h6);
        TICK = 1'b1; cyc(); TICK = 1'b0;
        chk("draw_exit", 32'(state2), 32'h2);
        chk("draw_hp", 32'(hp2), 32'b010_011);

        // Answer and TICK together: the tick is dropped.
        to_input2();
        TICK = 1'b1; av2 = 2'b10; ok2 = 2'b00; cyc();
        TICK = 1'b0; av2 = '0;
        chk("tickans_state", 32'(state2), 32'h7);
        chk("tickans_time", 32'(tl2), 32'd10);
        TICK = 1'b1; cyc(); TICK = 1'b0;
        // Withdraw and re-show the question.
        Q_SHOW = 1'b0; cyc();
        chk("withdraw_state", 32'(state2), 32'h3);
        chk("withdraw_lock", 32'(lock2), 32'b10);
        Q_SHOW = 1'b1; cyc();
        chk("reshow_lock", 32'(lock2), 32'b00);
        chk("reshow_time", 32'(tl2), 32'd10);

        // Let the answer timer run out.
        TICK = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        TICK = 1'b0;
        chk("tl_one", 32'(tl2), 32'd1);
        chk("tl_one_state", 32'(state2), 32'h4);
        TICK = 1'b1; cyc(); TICK = 1'b0;
        chk("timeout_state", 32'(state2), 32'h5);
        chk("timeout_time", 32'(tl2), 32'd0);
        TICK = 1'b1; cyc(); TICK = 1'b0;
        chk("timeout_exit", 32'(state2), 32'h2);

        // Three players, one HP each: player 2 wins outright.
        chk("p3_idle", 32'(state3), 32'h2);
        start3 = 3'b111; cyc(); start3 = '0;
        cyc();
        cyc();
        chk("p3_input", 32'(state3), 32'h4);
        av3 = 3'b100; ok3 = 3'b100; cyc(); av3 = '0; ok3 = '0;
        chk("p3_hit_who", 32'(who3), 32'h2);
        cyc();
        chk("p3_hp", 32'(hp3), 32'b001_000_000);
        TICK = 1'b1; cyc(); TICK = 1'b0;
        chk("p3_over", 32'(state3), 32'hA);
        chk("p3_winner", 32'(who3), 32'h2);
        start3 = 3'b001; cyc();
        start3 = 3'b010; cyc();
        start3 = 3'b000; cyc();
        chk("p3_over_wait", 32'(state3), 32'hA);
        start3 = 3'b100; cyc(); start3 = '0;
        cyc();
        chk("p3_restart", 32'(state3), 32'h2);
        chk("p3_reload", 32'(hp3), 32'b001_001_001);

        // Reset while in WRONG with player 0 locked.
        to_input2();
        av2 = 2'b01; ok2 = 2'b00; cyc(); av2 = '0;
        chk("pre_rst_state", 32'(state2), 32'h7);
        chk("pre_rst_lock", 32'(lock2), 32'b01);
        RST = 1'b1; cyc(); RST = 1'b0;
        chk("rst2_state", 32'(state2), 32'h2);
        chk("rst2_lock", 32'(lock2), 32'b00);
        chk("rst2_hp", 32'(hp2), 32'b011_011);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
